// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned imem requests, buffers {pc, instr} in a 2-entry FIFO
// and restarts on execute redirects. Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid_d,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d,
   input  logic        decode_ready,
   input  logic        pc_src_e,
   input  logic [31:0] pc_target_e,
   output logic        misalign_f
);

   localparam logic [31:0] NOP         = 32'h0000_0013;
   localparam logic [31:0] START_PC    = RESET_PC & ~32'h3;

   logic [31:0] fetchPc_q, fetchPc_d;
   logic [1:0]  outstanding_q, outstanding_d;
   logic [1:0]  drop_q, drop_d;
   logic [1:0]  fifoCount_q, fifoCount_d;
   logic        fifoHead_q, fifoHead_d;
   logic        tagHead_q, tagHead_d;
   logic [31:0] fifoPc_q [2];
   logic [31:0] fifoInstr_q [2];
   logic [31:0] tagPc_q [2];

   logic        halted;
   logic        pop, rspDrop, rspPush, reqFire;
   logic [2:0]  creditUsed;
   logic        fifoWrite, tagWrite;
   logic        fifoWrIdx, tagWrIdx;
   logic [31:0] targetAligned;

   assign targetAligned = pc_target_e & ~32'h3;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic halted_q, halted_d, misalign_q, misalignNow;

   assign misalignNow = pc_src_e && (pc_target_e[1:0] != 2'b00);
   assign halted_d    = pc_src_e ? misalignNow : halted_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halted_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         halted_q   <= halted_d;
         misalign_q <= misalignNow;
      end
   end

   assign halted     = halted_q;
   assign misalign_f = misalign_q;
`else
   assign halted     = 1'b0;
   assign misalign_f = 1'b0;
`endif

   assign instr_valid_d = (fifoCount_q != 2'd0);
   assign instr_d       = instr_valid_d ? fifoInstr_q[fifoHead_q] : NOP;
   assign pc_d          = instr_valid_d ? fifoPc_q[fifoHead_q] : 32'h0;
   assign pc_plus4_d    = instr_valid_d ? fifoPc_q[fifoHead_q] + 32'd4 : 32'h0;
   assign imem_req_addr = fetchPc_q;

   assign pop     = instr_valid_d && decode_ready;
   assign rspDrop = imem_rsp_valid && (drop_q != 2'd0);
   assign rspPush = imem_rsp_valid && (drop_q == 2'd0) && (outstanding_q != 2'd0);

   // Credits freed this cycle (dequeue, discarded response) already count as available,
   // which keeps a 1-cycle memory streaming and lets a redirect re-issue right away.
   assign creditUsed = 3'(outstanding_q) + 3'(drop_q) + 3'(fifoCount_q) - 3'(pop) - 3'(rspDrop);

   assign imem_req_valid = !reset && !pc_src_e && !halted && (creditUsed < 3'd2);
   assign reqFire        = imem_req_valid && imem_req_ready;

   always_comb begin
      fetchPc_d     = reqFire ? fetchPc_q + 32'd4 : fetchPc_q;
      outstanding_d = outstanding_q + 2'(reqFire) - 2'(rspPush);
      drop_d        = drop_q - 2'(rspDrop);
      fifoCount_d   = fifoCount_q + 2'(rspPush) - 2'(pop);
      fifoHead_d    = fifoHead_q ^ pop;
      tagHead_d     = tagHead_q ^ rspPush;
      fifoWrite     = rspPush;
      fifoWrIdx     = fifoHead_q ^ fifoCount_q[0];
      tagWrite      = reqFire;
      tagWrIdx      = tagHead_q ^ outstanding_q[0];
      if (pc_src_e) begin
         fetchPc_d     = targetAligned;
         outstanding_d = 2'd0;
         drop_d        = outstanding_q + drop_q
                         - 2'(imem_rsp_valid && (outstanding_q != 2'd0 || drop_q != 2'd0));
         fifoCount_d   = 2'd0;
         fifoWrite     = 1'b0;
         tagWrite      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetchPc_q     <= START_PC;
         outstanding_q <= 2'd0;
         drop_q        <= 2'd0;
         fifoCount_q   <= 2'd0;
         fifoHead_q    <= 1'b0;
         tagHead_q     <= 1'b0;
      end else begin
         fetchPc_q     <= fetchPc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         fifoCount_q   <= fifoCount_d;
         fifoHead_q    <= fifoHead_d;
         tagHead_q     <= tagHead_d;
      end
   end

   // Payload storage needs no reset: the counters decide what is valid.
   always_ff @(posedge clk) begin
      if (fifoWrite) begin
         fifoPc_q[fifoWrIdx]    <= tagPc_q[tagHead_q];
         fifoInstr_q[fifoWrIdx] <= imem_rsp_data;
      end
      if (tagWrite) begin
         tagPc_q[tagWrIdx] <= fetchPc_q;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus a sequential-PC stream reference.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid_d;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;
   logic        decode_ready;
   logic        pc_src_e;
   logic [31:0] pc_target_e;
   logic        misalign_f;

   localparam logic [31:0] NOP = 32'h0000_0013;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int memLat   = 1;
   int memLastDue = -100;
   logic [31:0] memAddrQ[$];
   int          memDueQ[$];

   logic        sReqValid, sFire, sPop, sInstrValid, sMis, sRspValid;
   logic [31:0] sReqAddr, sInstr, sPc, sPc4;

   fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr_valid_d(instr_valid_d), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
      .decode_ready(decode_ready), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
      .misalign_f(misalign_f)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   // One clock cycle: drive inputs and memory response at negedge, sample, update memory model.
   task automatic stepCycle(input logic rdy, input logic dec, input logic src, input logic [31:0] tgt);
      int due;
      @(negedge clk);
      imem_req_ready = rdy;
      decode_ready   = dec;
      pc_src_e       = src;
      pc_target_e    = tgt;
      if (memDueQ.size() != 0 && memDueQ[0] == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memWord(memAddrQ[0]);
         void'(memDueQ.pop_front());
         void'(memAddrQ.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      #1;
      sReqValid   = imem_req_valid;
      sReqAddr    = imem_req_addr;
      sInstrValid = instr_valid_d;
      sInstr      = instr_d;
      sPc         = pc_d;
      sPc4        = pc_plus4_d;
      sMis        = misalign_f;
      sRspValid   = imem_rsp_valid;
      sFire       = imem_req_valid && rdy;
      sPop        = instr_valid_d && dec;
      if (sFire) begin
         due = cyc + memLat;
         if (due <= memLastDue) due = memLastDue + 1;
         memLastDue = due;
         memAddrQ.push_back(imem_req_addr);
         memDueQ.push_back(due);
      end
      cyc++;
   endtask

   task automatic doReset();
      @(negedge clk);
      reset          = 1'b1;
      imem_req_ready = 1'b0;
      decode_ready   = 1'b0;
      pc_src_e       = 1'b0;
      pc_target_e    = 32'h0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      #1;
   endtask

   task automatic releaseReset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      memAddrQ.delete();
      memDueQ.delete();
      memLastDue = -100;
      cyc = 0;
      memLat = 1;
   endtask

   task automatic test_reset();
      releaseReset();
      for (int i = 0; i < 6; i++) stepCycle(1'b1, 1'b0, 1'b0, 32'h0);
      doReset();
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_valid got %b want 0", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h100) begin failures++; $display("[TB] FAIL reset_req_addr got %h want 00000100", imem_req_addr); end
      checks++; if (instr_valid_d !== 1'b0) begin failures++; $display("[TB] FAIL reset_instr_valid got %b want 0", instr_valid_d); end
      checks++; if (instr_d !== NOP) begin failures++; $display("[TB] FAIL reset_instr got %h want %h", instr_d, NOP); end
      checks++; if (pc_d !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got %h want 0", pc_d); end
      checks++; if (pc_plus4_d !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc4 got %h want 0", pc_plus4_d); end
      checks++; if (misalign_f !== 1'b0) begin failures++; $display("[TB] FAIL reset_misalign got %b want 0", misalign_f); end
   endtask

   task automatic test_stream();
      doReset(); releaseReset();
      for (int i = 0; i < 8; i++) begin
         stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
         checks++;
         if (sReqValid !== 1'b1 || sReqAddr !== 32'h100 + 32'(4 * i)) begin
            failures++; $display("[TB] FAIL stream_req cycle %0d got v=%b a=%h want v=1 a=%h", i, sReqValid, sReqAddr, 32'h100 + 32'(4 * i));
         end
         checks++;
         if (i < 2) begin
            if (sInstrValid !== 1'b0) begin failures++; $display("[TB] FAIL stream_early_valid cycle %0d got %b want 0", i, sInstrValid); end
         end else if (sInstrValid !== 1'b1 || sPc !== 32'h100 + 32'(4 * (i - 2)) || sPc4 !== 32'h104 + 32'(4 * (i - 2))
                      || sInstr !== memWord(32'h100 + 32'(4 * (i - 2)))) begin
            failures++; $display("[TB] FAIL stream_head cycle %0d got v=%b pc=%h pc4=%h instr=%h want pc=%h", i, sInstrValid, sPc, sPc4, sInstr, 32'h100 + 32'(4 * (i - 2)));
         end
      end
   endtask

   task automatic test_decode_stall();
      int accepted = 0;
      logic [31:0] expPc = 32'h100;
      doReset(); releaseReset();
      for (int i = 0; i < 5; i++) begin
         stepCycle(1'b1, 1'b0, 1'b0, 32'h0);
         if (sFire) accepted++;
      end
      checks++; if (accepted != 2) begin failures++; $display("[TB] FAIL stall_accepted got %0d want 2", accepted); end
      checks++; if (sReqValid !== 1'b0) begin failures++; $display("[TB] FAIL stall_req_valid got %b want 0", sReqValid); end
      checks++; if (sInstrValid !== 1'b1 || sPc !== 32'h100) begin failures++; $display("[TB] FAIL stall_head got v=%b pc=%h want v=1 pc=00000100", sInstrValid, sPc); end
      for (int i = 0; i < 10; i++) begin
         stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (sPop) begin
            checks++;
            if (sPc !== expPc || sInstr !== memWord(expPc)) begin failures++; $display("[TB] FAIL stall_resume_order got pc=%h instr=%h want pc=%h", sPc, sInstr, expPc); end
            expPc += 4;
         end
      end
      checks++; if (expPc !== 32'h128) begin failures++; $display("[TB] FAIL stall_resume_count got next=%h want 00000128", expPc); end
   endtask

   task automatic test_redirect_drop();
      logic [31:0] expPc = 32'h200;
      int pops = 0;
      doReset(); releaseReset();
      memLat = 3;
      stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
      stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (memAddrQ.size() != 2) begin failures++; $display("[TB] FAIL drop_setup got %0d outstanding want 2", memAddrQ.size()); end
      stepCycle(1'b1, 1'b1, 1'b1, 32'h200);
      checks++; if (sReqValid !== 1'b0) begin failures++; $display("[TB] FAIL drop_req_during_redirect got %b want 0", sReqValid); end
      stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (sReqValid !== 1'b1 || sReqAddr !== 32'h200) begin failures++; $display("[TB] FAIL drop_req_after_redirect got v=%b a=%h want v=1 a=00000200", sReqValid, sReqAddr); end
      for (int i = 0; i < 15; i++) begin
         stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (sPop) begin
            checks++;
            if (sPc !== expPc || sInstr !== memWord(expPc)) begin failures++; $display("[TB] FAIL drop_order got pc=%h want %h", sPc, expPc); end
            expPc += 4; pops++;
         end
      end
      checks++; if (pops < 5) begin failures++; $display("[TB] FAIL drop_progress got %0d pops want >=5", pops); end
   endtask

   task automatic test_redirect_coincident();
      logic [31:0] expPc = 32'h400;
      int pops = 0;
      doReset(); releaseReset();
      for (int i = 0; i < 5; i++) stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
      stepCycle(1'b1, 1'b1, 1'b1, 32'h400);
      checks++;
      if (sRspValid !== 1'b1 || sPop !== 1'b1 || sPc !== 32'h10c) begin
         failures++; $display("[TB] FAIL coinc_setup got rsp=%b pop=%b pc=%h want rsp=1 pop=1 pc=0000010c", sRspValid, sPop, sPc);
      end
      for (int i = 0; i < 12; i++) begin
         stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (sPop) begin
            checks++;
            if (sPc !== expPc || sInstr !== memWord(expPc)) begin failures++; $display("[TB] FAIL coinc_order got pc=%h want %h", sPc, expPc); end
            expPc += 4; pops++;
         end
      end
      checks++; if (pops < 6) begin failures++; $display("[TB] FAIL coinc_progress got %0d pops want >=6", pops); end
   endtask

   task automatic test_req_stall();
      doReset(); releaseReset();
      for (int i = 0; i < 4; i++) begin
         stepCycle(1'b0, 1'b1, 1'b0, 32'h0);
         checks++;
         if (sReqValid !== 1'b1 || sReqAddr !== 32'h100) begin failures++; $display("[TB] FAIL req_stall_hold cycle %0d got v=%b a=%h want v=1 a=00000100", i, sReqValid, sReqAddr); end
      end
      stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (sFire !== 1'b1 || sReqAddr !== 32'h100) begin failures++; $display("[TB] FAIL req_stall_release got fire=%b a=%h want 1/00000100", sFire, sReqAddr); end
      stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (sReqAddr !== 32'h104) begin failures++; $display("[TB] FAIL req_stall_next got %h want 00000104", sReqAddr); end
   endtask

   task automatic test_misalign();
      logic [31:0] expPc;
      int pops = 0;
      doReset(); releaseReset();
      stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
      stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
      stepCycle(1'b1, 1'b1, 1'b1, 32'h202);
      checks++; if (sReqValid !== 1'b0) begin failures++; $display("[TB] FAIL mis_req_during_redirect got %b want 0", sReqValid); end
`ifdef FETCH_MISALIGN_TRAP_EN
      stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (sMis !== 1'b1 || sReqValid !== 1'b0) begin failures++; $display("[TB] FAIL mis_pulse got mis=%b v=%b want mis=1 v=0", sMis, sReqValid); end
      for (int i = 0; i < 4; i++) begin
         stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
         checks++; if (sMis !== 1'b0 || sReqValid !== 1'b0) begin failures++; $display("[TB] FAIL mis_halted got mis=%b v=%b want 0/0", sMis, sReqValid); end
      end
      stepCycle(1'b1, 1'b1, 1'b1, 32'h300);
      stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (sReqValid !== 1'b1 || sReqAddr !== 32'h300) begin failures++; $display("[TB] FAIL mis_resume got v=%b a=%h want v=1 a=00000300", sReqValid, sReqAddr); end
      expPc = 32'h300;
`else
      stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (sMis !== 1'b0 || sReqValid !== 1'b1 || sReqAddr !== 32'h200) begin failures++; $display("[TB] FAIL mis_cleared got mis=%b v=%b a=%h want 0/1/00000200", sMis, sReqValid, sReqAddr); end
      expPc = 32'h200;
`endif
      for (int i = 0; i < 10; i++) begin
         stepCycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (sPop) begin
            checks++;
            if (sPc !== expPc || sMis !== 1'b0) begin failures++; $display("[TB] FAIL mis_order got pc=%h mis=%b want pc=%h mis=0", sPc, sMis, expPc); end
            expPc += 4; pops++;
         end
      end
      checks++; if (pops < 4) begin failures++; $display("[TB] FAIL mis_progress got %0d pops want >=4", pops); end
   endtask

   // Reference: decode sees consecutive word PCs from the last restart point; requests likewise.
   task automatic test_random();
      logic [31:0] expReq = 32'h100;
      logic [31:0] expDec = 32'h100;
      logic [31:0] tgt;
      logic        rdy, dec, src;
      int          pops = 0;
      doReset(); releaseReset();
      for (int i = 0; i < 3030; i++) begin
         if (i < 3000) begin
            memLat = $urandom_range(1, 4);
            rdy = ($urandom_range(0, 3) != 0);
            dec = ($urandom_range(0, 3) != 0);
            src = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(0, 3)) : $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt[1:0] = 2'b00;
`endif
         end else begin
            memLat = 1; rdy = 1'b1; dec = 1'b1; src = 1'b0; tgt = 32'h0;
         end
         stepCycle(rdy, dec, src, tgt);
         if (sPop) begin
            checks++;
            if (sPc !== expDec || sPc4 !== expDec + 32'd4 || sInstr !== memWord(expDec)) begin
               failures++; $display("[TB] FAIL rand_decode cycle %0d got pc=%h pc4=%h instr=%h want pc=%h instr=%h", i, sPc, sPc4, sInstr, expDec, memWord(expDec));
            end
            expDec += 4;
            if (i >= 3000) pops++;
         end
         if (!sInstrValid) begin
            checks++;
            if (sInstr !== NOP || sPc !== 32'h0 || sPc4 !== 32'h0) begin
               failures++; $display("[TB] FAIL rand_empty cycle %0d got instr=%h pc=%h pc4=%h want nop/0/0", i, sInstr, sPc, sPc4);
            end
         end
         if (sFire) begin
            checks++;
            if (sReqAddr !== expReq) begin failures++; $display("[TB] FAIL rand_req cycle %0d got %h want %h", i, sReqAddr, expReq); end
            expReq += 4;
         end
         if (src) begin
            checks++;
            if (sReqValid !== 1'b0) begin failures++; $display("[TB] FAIL rand_redirect_req cycle %0d got %b want 0", i, sReqValid); end
            expReq = tgt & ~32'h3;
            expDec = tgt & ~32'h3;
         end
      end
      checks++; if (pops < 20) begin failures++; $display("[TB] FAIL rand_drain got %0d pops want >=20", pops); end
   endtask

   initial begin
      reset          = 1'b1;
      imem_req_ready = 1'b0;
      decode_ready   = 1'b0;
      pc_src_e       = 1'b0;
      pc_target_e    = 32'h0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      $display("[TB] starting fetch_unit bench");
      test_reset();
      test_stream();
      test_decode_stall();
      test_redirect_drop();
      test_redirect_coincident();
      test_req_stall();
      test_misalign();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
